// File: rtl/ultra_sonic_scheduler_if.sv
// Sensor-bank and result bus of the ultra_sonic round-robin scheduler.
// ULTRA_SCHED_RESULT_REGS_EN adds the per-channel last-result read port.
interface ultra_sonic_scheduler_if #(
    parameter int unsigned N_SENSORS = 4,
    parameter int unsigned COUNT_W   = 23
);
    localparam int unsigned ID_W = $clog2(N_SENSORS);

    logic                           enable;
    logic [N_SENSORS-1:0]           sensor_mask;
    logic [N_SENSORS-1:0]           start_out;
    logic [N_SENSORS-1:0]           active_in;
    logic [N_SENSORS-1:0]           count_ready_in;
    logic [N_SENSORS*COUNT_W-1:0]   count_in;
    logic                           result_valid;
    logic [ID_W-1:0]                result_id;
    logic [COUNT_W-1:0]             result_count;
    logic                           result_timeout;
    logic                           busy;
`ifdef ULTRA_SCHED_RESULT_REGS_EN
    logic [ID_W-1:0]                rd_sel;
    logic [COUNT_W-1:0]             rd_count;
    logic                           rd_fresh;

    modport master (
        input  enable, sensor_mask, active_in, count_ready_in, count_in, rd_sel,
        output start_out, result_valid, result_id, result_count, result_timeout, busy,
               rd_count, rd_fresh
    );
    modport slave (
        output enable, sensor_mask, active_in, count_ready_in, count_in, rd_sel,
        input  start_out, result_valid, result_id, result_count, result_timeout, busy,
               rd_count, rd_fresh
    );
`else
    modport master (
        input  enable, sensor_mask, active_in, count_ready_in, count_in,
        output start_out, result_valid, result_id, result_count, result_timeout, busy
    );
    modport slave (
        output enable, sensor_mask, active_in, count_ready_in, count_in,
        input  start_out, result_valid, result_id, result_count, result_timeout, busy
    );
`endif
endinterface

// File: rtl/ultra_sonic_scheduler.sv
// Round-robin ranging-slot sequencer for a bank of ultra_sonic channels.
// Optional per-channel last-result register file under ULTRA_SCHED_RESULT_REGS_EN.
module ultra_sonic_scheduler #(
    parameter int unsigned N_SENSORS      = 4,
    parameter int unsigned COUNT_W        = 23,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned HOLDOFF_CYCLES = 3000000
) (
    input logic                      clk,
    input logic                      reset_all,
    ultra_sonic_scheduler_if.master  bus
);
    localparam int unsigned ID_W   = $clog2(N_SENSORS);
    localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned HCNT_W = $clog2(HOLDOFF_CYCLES + 1);

    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TCNT_W-1:0] TCNT_MAX  = TCNT_W'(TIMEOUT_CYCLES);
    localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [HCNT_W-1:0] HCNT_MAX  = HCNT_W'(HOLDOFF_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_START,
        S_WAIT,
        S_HOLDOFF
    } state_t;

    state_t                 state;
    logic [ID_W-1:0]        sel;
    logic [ID_W-1:0]        rr_last;
    logic [TCNT_W-1:0]      tcnt;
    logic [HCNT_W-1:0]      hcnt;
    logic [N_SENSORS-1:0]   start_q;
    logic                   result_valid_q;
    logic [ID_W-1:0]        result_id_q;
    logic [COUNT_W-1:0]     result_count_q;
    logic                   result_timeout_q;
    logic                   busy_q;

    logic [ID_W-1:0]        next_sel_c;
    logic                   found_c;
    int unsigned            scan_idx;
    logic                   active_c;
    logic                   ready_c;
    logic                   tmo_c;
    logic [COUNT_W-1:0]     count_sel_c;

    // First participating channel strictly after rr_last, wrapping.
    always_comb begin
        next_sel_c = rr_last;
        found_c    = 1'b0;
        scan_idx   = 0;
        for (int unsigned k = 1; k <= N_SENSORS; k++) begin
            scan_idx = 32'(rr_last) + k;
            if (scan_idx >= N_SENSORS) begin
                scan_idx = scan_idx - N_SENSORS;
            end
            if (!found_c && bus.sensor_mask[ID_W'(scan_idx)]) begin
                next_sel_c = ID_W'(scan_idx);
                found_c    = 1'b1;
            end
        end
    end

    assign active_c    = bus.active_in[sel];
    assign ready_c     = bus.count_ready_in[sel];
    assign tmo_c       = (tcnt == TCNT_LAST);
    assign count_sel_c = bus.count_in[32'(sel) * COUNT_W +: COUNT_W];

    always_ff @(posedge clk or posedge reset_all) begin
        if (reset_all) begin
            state            <= S_IDLE;
            sel              <= '0;
            rr_last          <= ID_W'(N_SENSORS - 1);
            tcnt             <= '0;
            hcnt             <= '0;
            start_q          <= '0;
            result_valid_q   <= 1'b0;
            result_id_q      <= '0;
            result_count_q   <= '0;
            result_timeout_q <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.enable && (bus.sensor_mask != '0)) begin
                        state  <= S_SELECT;
                        busy_q <= 1'b1;
                    end
                end
                S_SELECT: begin
                    if (!bus.enable || !found_c) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        sel     <= next_sel_c;
                        start_q <= N_SENSORS'(1) << next_sel_c;
                        tcnt    <= '0;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    // A channel that never goes active still times out.
                    if (tmo_c) begin
                        start_q          <= '0;
                        result_valid_q   <= 1'b1;
                        result_id_q      <= sel;
                        result_count_q   <= '1;
                        result_timeout_q <= 1'b1;
                        rr_last          <= sel;
                        hcnt             <= '0;
                        state            <= S_HOLDOFF;
                    end else begin
                        if (tcnt != TCNT_MAX) begin
                            tcnt <= tcnt + TCNT_W'(1);
                        end
                        if (active_c) begin
                            start_q <= '0;
                            state   <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // Ready is checked first so it wins a tie with the timeout.
                    if (ready_c) begin
                        result_valid_q   <= 1'b1;
                        result_id_q      <= sel;
                        result_count_q   <= count_sel_c;
                        result_timeout_q <= 1'b0;
                        rr_last          <= sel;
                        hcnt             <= '0;
                        state            <= S_HOLDOFF;
                    end else if (tmo_c) begin
                        result_valid_q   <= 1'b1;
                        result_id_q      <= sel;
                        result_count_q   <= '1;
                        result_timeout_q <= 1'b1;
                        rr_last          <= sel;
                        hcnt             <= '0;
                        state            <= S_HOLDOFF;
                    end else if (tcnt != TCNT_MAX) begin
                        tcnt <= tcnt + TCNT_W'(1);
                    end
                end
                S_HOLDOFF: begin
                    if (hcnt == HCNT_LAST) begin
                        if (bus.enable) begin
                            state <= S_SELECT;
                        end else begin
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end
                    end else if (hcnt != HCNT_MAX) begin
                        hcnt <= hcnt + HCNT_W'(1);
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    start_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.start_out      = start_q;
    assign bus.result_valid   = result_valid_q;
    assign bus.result_id      = result_id_q;
    assign bus.result_count   = result_count_q;
    assign bus.result_timeout = result_timeout_q;
    assign bus.busy           = busy_q;

`ifdef ULTRA_SCHED_RESULT_REGS_EN
    logic [COUNT_W-1:0]   last_count [N_SENSORS];
    logic [N_SENSORS-1:0] fresh;
    logic                 rd_in_range_c;

    // A write on the same edge beats the read-side clear.
    always_ff @(posedge clk or posedge reset_all) begin
        if (reset_all) begin
            for (int unsigned i = 0; i < N_SENSORS; i++) begin
                last_count[i] <= '0;
            end
            fresh <= '0;
        end else begin
            for (int unsigned i = 0; i < N_SENSORS; i++) begin
                if (result_valid_q && (result_id_q == ID_W'(i))) begin
                    last_count[i] <= result_count_q;
                    fresh[i]      <= 1'b1;
                end else if (bus.rd_sel == ID_W'(i)) begin
                    fresh[i] <= 1'b0;
                end
            end
        end
    end

    assign rd_in_range_c = (32'(bus.rd_sel) < N_SENSORS);
    assign bus.rd_count  = rd_in_range_c ? last_count[bus.rd_sel] : '0;
    assign bus.rd_fresh  = rd_in_range_c ? fresh[bus.rd_sel] : 1'b0;
`endif

endmodule

// File: tb/tb_ultra_sonic_scheduler.sv
// Scoreboard bench for ultra_sonic_scheduler with behavioural channel models.
// Checks the read port too when ULTRA_SCHED_RESULT_REGS_EN is defined.
module tb_ultra_sonic_scheduler;
    localparam int unsigned N   = 4;
    localparam int unsigned CW  = 23;
    localparam int          TO  = 100;
    localparam int          HO  = 8;

    typedef struct {
        int              id;
        logic [CW-1:0]   count;
        logic            timeout;
    } exp_t;

    logic clk = 1'b0;
    logic reset_all = 1'b1;

    ultra_sonic_scheduler_if #(.N_SENSORS(N), .COUNT_W(CW)) bus ();

    ultra_sonic_scheduler #(
        .N_SENSORS(N), .COUNT_W(CW),
        .TIMEOUT_CYCLES(TO), .HOLDOFF_CYCLES(HO)
    ) dut (
        .clk(clk),
        .reset_all(reset_all),
        .bus(bus)
    );

    always #5 clk = ~clk;

    exp_t          q[$];
    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            n_results = 0;
    int            last_valid = -1000;
    int            act_dly [N];
    int            rdy_dly [N];
    logic [CW-1:0] cnt_val [N];
    bit            run [N];
    int            age [N];
    int            model_rr = N - 1;
    logic [N-1:0]  act_v = '0;
    logic [N-1:0]  rdy_v = '0;

    assign bus.active_in      = act_v;
    assign bus.count_ready_in = rdy_v;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic int next_id(input int rr, input logic [N-1:0] m);
        for (int k = 1; k <= int'(N); k++) begin
            int idx;
            idx = (rr + k) % int'(N);
            if (m[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic set_channel(input int ch, input int a, input int r, input int c);
        act_dly[ch] = a;
        rdy_dly[ch] = r;
        cnt_val[ch] = CW'(c);
        bus.count_in[ch*CW +: CW] = CW'(c);
    endtask

    // Channel behaviour plus reference model: a start means a new expected result.
    always @(negedge clk) begin
        if (reset_all) begin
            for (int i = 0; i < int'(N); i++) run[i] = 1'b0;
            act_v    = '0;
            rdy_v    = '0;
            model_rr = N - 1;
            q.delete();
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                if (!run[i] && bus.start_out[i]) begin
                    int   p;
                    bit   ok;
                    exp_t e;
                    p = next_id(model_rr, bus.sensor_mask);
                    check("start_id", i, p);
                    check("start_onehot", $countones(bus.start_out), 1);
                    check("start_while_enabled", int'(bus.enable), 1);
                    if (p >= 0) begin
                        ok = (rdy_dly[p] >= 0) && (act_dly[p] + rdy_dly[p] <= TO - 1);
                        e.id      = p;
                        e.count   = ok ? cnt_val[p] : '1;
                        e.timeout = !ok;
                        q.push_back(e);
                        model_rr = p;
                    end
                    run[i] = 1'b1;
                    age[i] = 0;
                end
                if (run[i]) begin
                    if ((rdy_dly[i] >= 0 && age[i] > act_dly[i] + rdy_dly[i]) || age[i] > TO + 5) begin
                        run[i]   = 1'b0;
                        act_v[i] = 1'b0;
                        rdy_v[i] = 1'b0;
                    end else begin
                        act_v[i] = (age[i] >= act_dly[i]);
                        rdy_v[i] = (rdy_dly[i] >= 0) && (age[i] == act_dly[i] + rdy_dly[i]);
                    end
                    age[i]++;
                end
            end
        end
    end

    // Monitor: every result pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!reset_all && bus.result_valid) begin
            exp_t e;
            n_results++;
            check("result_gap_ok", int'(cyc - last_valid >= HO + 1), 1);
            last_valid = cyc;
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got id %0d, expected none", bus.result_id);
            end else begin
                e = q.pop_front();
                check("result_id", int'(bus.result_id), e.id);
                check("result_count", int'(bus.result_count), int'(e.count));
                check("result_timeout", int'(bus.result_timeout), int'(e.timeout));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_results(input int n, input int budget);
        int target;
        int c;
        target = n_results + n;
        c = 0;
        while (n_results < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        #1;
        check("wait_results_in_budget", int'(n_results >= target), 1);
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while (bus.busy && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("reached_idle", int'(bus.busy), 0);
    endtask

    task automatic wait_active(input int ch, input int budget);
        int c;
        c = 0;
        while (!act_v[ch] && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("channel_went_active", int'(act_v[ch]), 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_start_out"}, int'(bus.start_out), 0);
        check({tag, "_result_valid"}, int'(bus.result_valid), 0);
        check({tag, "_result_id"}, int'(bus.result_id), 0);
        check({tag, "_result_count"}, int'(bus.result_count), 0);
        check({tag, "_result_timeout"}, int'(bus.result_timeout), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
    endtask

    task automatic default_channels();
        for (int i = 0; i < int'(N); i++) set_channel(i, 2, 20, 10 + i);
    endtask

    initial begin
        bus.enable      = 1'b0;
        bus.sensor_mask = '0;
        bus.count_in    = '0;
`ifdef ULTRA_SCHED_RESULT_REGS_EN
        bus.rd_sel      = '0;
`endif
        default_channels();

        // Reset state
        tick(3);
        check_outputs_zero("reset");
        reset_all = 1'b0;
        tick(2);

        // Full mask: ids 0,1,2,3,0
        bus.sensor_mask = 4'b1111;
        bus.enable      = 1'b1;
        wait_results(5, 1500);
        bus.enable = 1'b0;
        wait_idle(60);

        // Sparse mask: ids 1 and 3 alternate
        bus.sensor_mask = 4'b1010;
        bus.enable      = 1'b1;
        wait_results(4, 1200);
        bus.enable = 1'b0;
        wait_idle(60);

        // Channel 2 never ready -> timeout, scan continues
        bus.sensor_mask = 4'b1111;
        set_channel(2, 2, -1, 12);
        bus.enable = 1'b1;
        wait_results(4, 1500);
        bus.enable = 1'b0;
        wait_idle(60);

        // Ready on the last timeout cycle (ch2) and one cycle past it (ch1)
        set_channel(2, 2, TO - 3, 12);
        set_channel(1, 2, TO - 2, 11);
        bus.enable = 1'b1;
        wait_results(4, 1500);
        bus.enable = 1'b0;
        wait_idle(60);
        default_channels();

        // enable dropped while id 1 is measuring
        bus.enable = 1'b1;
        wait_active(1, 400);
        tick(3);
        bus.enable = 1'b0;
        wait_results(1, 200);
        wait_idle(60);
        check("holdoff_to_idle_cycles", cyc - last_valid, HO);
        bus.sensor_mask = '0;
        bus.enable      = 1'b1;
        tick(20);
        check("empty_mask_busy", int'(bus.busy), 0);
        check("empty_mask_start", int'(bus.start_out), 0);
        bus.enable      = 1'b0;
        bus.sensor_mask = 4'b1111;
        tick(2);

        // Reset in the middle of a measurement
        bus.enable = 1'b1;
        wait_active(2, 400);
        tick(5);
        #2 reset_all = 1'b1;
        #1 check_outputs_zero("midreset");
        tick(3);
        reset_all = 1'b0;
        wait_results(4, 1500);
        bus.enable = 1'b0;
        wait_idle(60);

`ifdef ULTRA_SCHED_RESULT_REGS_EN
        bus.rd_sel = 2'd3;
        #1;
        check("rd_count_ch3", int'(bus.rd_count), 13);
        check("rd_fresh_first", int'(bus.rd_fresh), 1);
        @(negedge clk);
        #1;
        check("rd_fresh_cleared", int'(bus.rd_fresh), 0);
`endif

        tick(5);
        check("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end
endmodule
